// File: rtl/layer_mvm_param.sv
// Fully-connected layer y = act(W*x + b) using P MAC lanes and double-buffered input vectors.
// Weights and biases are read from external synchronous ROMs with a 1-cycle read latency.
module layer_mvm_param #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int P    = 1,
  parameter int T    = 16,
  parameter int RELU = 1,
  localparam int G   = M / P,
  localparam int WAW = $clog2(G * N),
  localparam int BAW = (G > 1) ? $clog2(G) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [T-1:0]     data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [T-1:0]     data_out,
  output logic [WAW-1:0]   w_addr,
  input  logic [P*T-1:0]   w_data,
  output logic [BAW-1:0]   b_addr,
  input  logic [P*T-1:0]   b_data
);

  localparam int JW = $clog2(N);
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int AW = 2 * T + $clog2(N) + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [BAW-1:0]  g_q, g_d;
  logic [JW-1:0]   j_q, j_d;
  logic [JW-1:0]   fill_idx_q, fill_idx_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            comp_bank_q, comp_bank_d;
  logic            fill_bank_q, fill_bank_d;
  logic [1:0]      full_q, full_d;
  logic            ready_en_q;
  logic            s_fire, fill_done;
  logic [1:0]      avail;

  logic signed [T-1:0]    x_mem [2][N];
  logic signed [T-1:0]    x_rd_q;
  logic                   mem_v_q, prod_v_q;
  logic signed [2*T-1:0]  prod_q [P];
  logic signed [AW-1:0]   acc_q [P];
  logic signed [AW-1:0]   acc_d [P];
  logic signed [AW-1:0]   acc_sel;
  logic signed [T-1:0]    y_sat;

  // A bank stays full from its last write until its last group is emitted,
  // so the full flag alone also covers "in use by compute".
  assign s_ready   = ready_en_q && !full_q[fill_bank_q];
  assign s_fire    = s_valid && s_ready;
  assign fill_done = s_fire && (fill_idx_q == JW'(N - 1));
  assign avail[0]  = full_q[0] || (fill_done && !fill_bank_q);
  assign avail[1]  = full_q[1] || (fill_done && fill_bank_q);

  assign w_addr = WAW'(32'(g_q) * N + 32'(j_q));
  assign b_addr = g_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch can be inferred.
    state_d     = state_q;
    g_d         = g_q;
    j_d         = j_q;
    dcnt_d      = dcnt_q;
    lane_d      = lane_q;
    comp_bank_d = comp_bank_q;
    fill_bank_d = fill_bank_q;
    fill_idx_d  = fill_idx_q;
    full_d      = full_q;

    if (fill_done) begin
      full_d[fill_bank_q] = 1'b1;
      fill_bank_d         = !fill_bank_q;
      fill_idx_d          = '0;
    end else if (s_fire) begin
      fill_idx_d = fill_idx_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: if (avail[comp_bank_q]) state_d = S_BIAS;
      S_BIAS: begin
        state_d = S_MAC;
        j_d     = '0;
      end
      S_MAC: begin
        if (j_q == JW'(N - 1)) begin
          state_d = S_DRAIN;
          j_d     = '0;
          dcnt_d  = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      // Three cycles cover memory, product and final accumulate stages.
      S_DRAIN: begin
        if (dcnt_q == 2'd2) begin
          state_d = S_OUT;
          lane_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          if (lane_q == LW'(P - 1)) begin
            lane_d = '0;
            if (g_q == BAW'(G - 1)) begin
              g_d                 = '0;
              full_d[comp_bank_q] = 1'b0;
              comp_bank_d         = !comp_bank_q;
              state_d             = avail[!comp_bank_q] ? S_BIAS : S_IDLE;
            end else begin
              g_d     = g_q + 1'b1;
              state_d = S_BIAS;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bias lands on the first MAC cycle; products accumulate as they emerge.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      acc_d[p] = acc_q[p];
      if (state_q == S_MAC && j_q == '0)
        acc_d[p] = {{(AW-T){b_data[p*T+T-1]}}, b_data[p*T +: T]};
      else if (prod_v_q)
        acc_d[p] = acc_q[p] + {{(AW-2*T){prod_q[p][2*T-1]}}, prod_q[p]};
    end
  end

  always_comb begin
    acc_sel = acc_q[0];
    for (int p = 1; p < P; p++)
      if (lane_q == LW'(p)) acc_sel = acc_q[p];
    if (acc_sel > SAT_MAX)      y_sat = SAT_MAX[T-1:0];
    else if (acc_sel < SAT_MIN) y_sat = SAT_MIN[T-1:0];
    else                        y_sat = acc_sel[T-1:0];
    m_valid  = (state_q == S_OUT);
    data_out = '0;
    if (m_valid) data_out = (RELU != 0 && y_sat[T-1]) ? '0 : y_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      j_q         <= '0;
      dcnt_q      <= '0;
      lane_q      <= '0;
      comp_bank_q <= 1'b0;
      fill_bank_q <= 1'b0;
      fill_idx_q  <= '0;
      full_q      <= '0;
      ready_en_q  <= 1'b0;
      mem_v_q     <= 1'b0;
      prod_v_q    <= 1'b0;
      for (int p = 0; p < P; p++) acc_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      j_q         <= j_d;
      dcnt_q      <= dcnt_d;
      lane_q      <= lane_d;
      comp_bank_q <= comp_bank_d;
      fill_bank_q <= fill_bank_d;
      fill_idx_q  <= fill_idx_d;
      full_q      <= full_d;
      ready_en_q  <= 1'b1;
      mem_v_q     <= (state_q == S_MAC);
      prod_v_q    <= mem_v_q;
      acc_q       <= acc_d;
    end
  end

  // NOTE: x banks and datapath registers carry no reset; they are only consumed
  // behind a full flag or a pipeline valid bit, which are reset.
  always_ff @(posedge clk) begin
    if (s_fire) x_mem[fill_bank_q][fill_idx_q] <= data_in;
    x_rd_q <= x_mem[comp_bank_q][j_q];
    for (int p = 0; p < P; p++)
      prod_q[p] <= $signed(w_data[p*T +: T]) * x_rd_q;
  end

endmodule

// File: tb/tb_layer_mvm_param.sv
// Randomized self-checking bench for layer_mvm_param: two instances (ReLU on/off) driven in
// lockstep, checked against a plain-arithmetic model of y = act(sat(W*x + b)).
module tb_layer_mvm_param;
  localparam int M   = 4;
  localparam int N   = 4;
  localparam int P   = 2;
  localparam int T   = 16;
  localparam int G   = M / P;
  localparam int WAW = $clog2(G * N);
  localparam int BAW = (G > 1) ? $clog2(G) : 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  logic [T-1:0] data_in = '0;
  logic s_ready0, s_ready1, m_valid0, m_valid1;
  logic [T-1:0] dout0, dout1;
  logic [WAW-1:0] w_addr0, w_addr1;
  logic [BAW-1:0] b_addr0, b_addr1;
  logic [P*T-1:0] w_data0, w_data1, b_data0, b_data1;

  always #5 clk = ~clk;

  layer_mvm_param #(.M(M), .N(N), .P(P), .T(T), .RELU(1)) dut_relu (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0), .data_in(data_in),
    .m_valid(m_valid0), .m_ready(m_ready), .data_out(dout0),
    .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0));

  layer_mvm_param #(.M(M), .N(N), .P(P), .T(T), .RELU(0)) dut_lin (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .data_in(data_in),
    .m_valid(m_valid1), .m_ready(m_ready), .data_out(dout1),
    .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1));

  int wm [M][N];
  int bv [M];
  int xv [N];

  typedef struct {int y_relu; int y_lin;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int first_mv = -1;
  int out_cnt  = 0;
  int hs_cyc   = 0;
  bit saw_low  = 0;
  bit sending  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [P*T-1:0] rom_w(input logic [WAW-1:0] a);
    logic [P*T-1:0] r;
    int g, j;
    g = int'(a) / N;
    j = int'(a) % N;
    r = '0;
    for (int p = 0; p < P; p++)
      if (g * P + p < M) r[p*T +: T] = T'(wm[g*P+p][j]);
    return r;
  endfunction

  function automatic logic [P*T-1:0] rom_b(input logic [BAW-1:0] a);
    logic [P*T-1:0] r;
    r = '0;
    for (int p = 0; p < P; p++)
      if (int'(a) * P + p < M) r[p*T +: T] = T'(bv[int'(a)*P+p]);
    return r;
  endfunction

  always @(posedge clk) begin
    w_data0 <= rom_w(w_addr0);
    w_data1 <= rom_w(w_addr1);
    b_data0 <= rom_b(b_addr0);
    b_data1 <= rom_b(b_addr1);
    cyc     <= cyc + 1;
  end

  function automatic int rnd_t();
    logic [T-1:0] v;
    v = T'($urandom);
    return int'($signed(v));
  endfunction

  // Reference: full-precision dot product, saturate to T bits, optional ReLU.
  task automatic push_expected();
    longint s, hi, lo;
    exp_t e;
    hi = (longint'(1) <<< (T - 1)) - 1;
    lo = -(longint'(1) <<< (T - 1));
    for (int i = 0; i < M; i++) begin
      s = longint'(bv[i]);
      for (int j = 0; j < N; j++) s += longint'(wm[i][j]) * longint'(xv[j]);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      e.y_lin  = int'(s);
      e.y_relu = (s < 0) ? 0 : int'(s);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (m_valid0 || m_valid1)) begin
      if (first_mv < 0) first_mv = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        check("m_valid_relu", 32'(m_valid0), 1);
        check("m_valid_lin", 32'(m_valid1), 1);
        check("data_out_relu", int'($signed(dout0)), exp_q[0].y_relu);
        check("data_out_lin", int'($signed(dout1)), exp_q[0].y_lin);
        if (m_ready) begin
          void'(exp_q.pop_front());
          out_cnt++;
        end
      end
    end
  end

  task automatic send_vec(input bit hold);
    int budget;
    push_expected();
    for (int j = 0; j < N; j++) begin
      data_in = T'(xv[j]);
      s_valid = 1'b1;
      budget  = 500;
      @(negedge clk);
      while (!s_ready0 && budget > 0) begin
        saw_low = 1'b1;
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    hs_cyc = cyc;
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd);
    int budget;
    budget = 3000;
    while ((exp_q.size() != 0 || sending) && budget > 0) begin
      if (rnd) m_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      budget--;
    end
    m_ready = 1'b1;
    check("drain_complete", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rand_weights();
    for (int i = 0; i < M; i++) begin
      bv[i] = rnd_t();
      for (int j = 0; j < N; j++) wm[i][j] = rnd_t();
    end
  endtask

  task automatic rand_x();
    for (int j = 0; j < N; j++) xv[j] = rnd_t();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v1, v2, cnt_before, budget;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready0), 0);
    check("rst_m_valid", 32'(m_valid0), 0);
    check("rst_data_out", 32'(dout0), 0);
    check("rst_w_addr", 32'(w_addr0), 0);
    check("rst_b_addr", 32'(b_addr0), 0);
    check("rst_m_valid_lin", 32'(m_valid1), 0);
    reset = 1'b0;
    check("s_ready_first_cycle", 32'(s_ready0), 0);
    @(posedge clk); #1;
    check("s_ready_rise", 32'(s_ready0), 1);
    check("s_ready_rise_lin", 32'(s_ready1), 1);

    // Basic: all-ones weights, zero bias, x = 1..4.
    for (int i = 0; i < M; i++) begin
      bv[i] = 0;
      for (int j = 0; j < N; j++) wm[i][j] = 1;
    end
    for (int j = 0; j < N; j++) xv[j] = j + 1;
    first_mv = -1;
    send_vec(1'b0);
    wait_drain(1'b0);
    check("first_output_latency", first_mv - hs_cyc, N + 4);

    // Saturation, ReLU and bias/sign, two vectors back to back.
    for (int j = 0; j < N; j++) begin
      wm[0][j] = 32767;
      wm[1][j] = -32768;
      wm[2][j] = (j % 2 == 0) ? (j + 1) : -(j + 1);
      wm[3][j] = rnd_t();
    end
    bv[0] = 0; bv[1] = 0; bv[2] = 100; bv[3] = $urandom_range(0, 200) - 100;
    for (int j = 0; j < N; j++) xv[j] = 32767;
    send_vec(1'b1);
    for (int j = 0; j < N; j++) xv[j] = j + 5;
    send_vec(1'b0);
    wait_drain(1'b0);

    // Backpressure: hold m_ready low for 5 cycles with an output pending.
    rand_weights();
    rand_x();
    m_ready = 1'b0;
    send_vec(1'b0);
    budget = 100;
    while (!m_valid0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("bp_valid_seen", 32'(m_valid0), 1);
    cnt_before = out_cnt;
    repeat (5) begin
      check("bp_m_valid_held", 32'(m_valid0), 1);
      if (exp_q.size() != 0) check("bp_data_held", int'($signed(dout0)), exp_q[0].y_relu);
      @(posedge clk); #1;
    end
    check("bp_no_handshake", out_cnt - cnt_before, 0);
    wait_drain(1'b1);

    // Double buffering: three vectors with s_valid held high.
    rand_weights();
    first_mv = -1;
    saw_low  = 1'b0;
    rand_x();
    send_vec(1'b1);
    v1 = hs_cyc;
    rand_x();
    send_vec(1'b1);
    v2 = hs_cyc;
    rand_x();
    send_vec(1'b0);
    check("db_no_bubble", v2 - v1, N);
    check("db_v2_during_compute", 32'(v2 < first_mv), 1);
    check("db_s_ready_dropped", 32'(saw_low), 1);
    wait_drain(1'b0);

    // Random m_ready while streaming four vectors.
    rand_weights();
    sending = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          rand_x();
          send_vec(k < 3);
        end
        sending = 1'b0;
      end
      wait_drain(1'b1);
    join

    // Reset during the MAC phase of group 1.
    rand_weights();
    rand_x();
    cnt_before = out_cnt;
    send_vec(1'b0);
    budget = 200;
    while (out_cnt != cnt_before + P && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("grp1_b_addr", 32'(b_addr0), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("grp1_w_addr", 32'(w_addr0), N + 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_s_ready", 32'(s_ready0), 0);
    check("mid_rst_m_valid", 32'(m_valid0), 0);
    check("mid_rst_data_out", 32'(dout0), 0);
    check("mid_rst_w_addr", 32'(w_addr0), 0);
    check("mid_rst_b_addr", 32'(b_addr0), 0);
    check("mid_rst_m_valid_lin", 32'(m_valid1), 0);
    @(posedge clk); #1;
    check("mid_rst_s_ready_rise", 32'(s_ready0), 1);
    rand_x();
    send_vec(1'b0);
    wait_drain(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
